piradip_axis_fifo_reader: RTL

PIRADIP_AXIS_FIFO_READER -- requirements
Module: piradip_axis_fifo_reader

---
 rtl/piradip_axis_pkg.sv | 18 +
 rtl/piradip_axis_fifo_reader_if.sv | 12 +
 rtl/piradip_ram_1w1r.sv | 22 ++
 rtl/piradip_axis_fifo_reader.sv | 102 ++++++++++
 4 files changed

// File: rtl/piradip_axis_pkg.sv
// Shared sizing helpers for the AXI-Stream FIFO reader.
// Entry layout is {tlast, tdata}; the tlast bit exists only with PIRADIP_AXIS_FIFO_READER_TLAST_EN.
package piradip_axis_pkg;

    // Occupancy and pointer width: one extra MSB separates full from empty.
    function automatic int unsigned cnt_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned entry_width(int unsigned width);
`ifdef PIRADIP_AXIS_FIFO_READER_TLAST_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piradip_axis_fifo_reader_if.sv
// AXI-Stream beat channel: master drives valid/data/last, slave drives ready.
interface piradip_axis_fifo_reader_if #(
    parameter int unsigned WIDTH = 32
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;
    logic             tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/piradip_ram_1w1r.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module piradip_ram_1w1r #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/piradip_axis_fifo_reader.sv
// AXI-Stream to first-word-fall-through FIFO with occupancy, underflow and packet tracking.
// Define PIRADIP_AXIS_FIFO_READER_TLAST_EN to store tlast and count complete packets.
module piradip_axis_fifo_reader
    import piradip_axis_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned PROG_FULL_THRESH = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    piradip_axis_fifo_reader_if.slave    s_axis,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_last,
    output logic                         empty,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         pkt_avail,
    output logic                         underflow
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned AW = CW - 1;
    localparam int unsigned EW = entry_width(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // A nonzero threshold only matters when it is tighter than the physical depth.
    localparam logic [CW-1:0] LIMIT_C =
        (PROG_FULL_THRESH != 0 && PROG_FULL_THRESH < DEPTH) ? CW'(PROG_FULL_THRESH) : DEPTH_C;

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          underflow_q;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign count         = wr_ptr - rd_ptr;
    assign empty         = (wr_ptr == rd_ptr);
    assign s_axis.tready = ~rst & (count < LIMIT_C);
    assign push          = s_axis.tvalid & s_axis.tready;
    assign pop           = rd_en & ~empty;
    assign underflow     = underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            underflow_q <= rd_en & empty;
        end
    end

`ifdef PIRADIP_AXIS_FIFO_READER_TLAST_EN
    logic [CW-1:0] pkt_cnt;
    logic          pkt_in;
    logic          pkt_out;

    assign wr_entry  = {s_axis.tlast, s_axis.tdata};
    assign rd_data   = rd_entry[WIDTH-1:0];
    assign rd_last   = rd_entry[WIDTH];
    assign pkt_in    = push & s_axis.tlast;
    assign pkt_out   = pop & rd_last;
    assign pkt_avail = (pkt_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (pkt_in & ~pkt_out) begin
            pkt_cnt <= pkt_cnt + CW'(1);
        end else if (~pkt_in & pkt_out) begin
            pkt_cnt <= pkt_cnt - CW'(1);
        end
    end
`else
    logic unused_tlast;

    assign unused_tlast = s_axis.tlast;
    assign wr_entry     = s_axis.tdata;
    assign rd_data      = rd_entry;
    assign rd_last      = 1'b0;
    assign pkt_avail    = ~empty;
`endif

    piradip_ram_1w1r #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );
endmodule
